stream_mux_2to1: RTL and testbench
==================================

# stream_mux_2to1

Two-source packet stream multiplexer: merges two valid/ready input streams onto one output stream, one whole packet at a time, with round-robin arbitration between sources. It is the gathering counterpart of the day-2 one-to-two demultiplexer and sits wherever two producers share a single downstream consumer. The output stage is one register, so throughput is one beat per cycle.

## Interface
Parameters:
- DATA_W, 8, width of the data bus on each input and on the output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s0_valid  input  1  source 0 beat valid.
- s0_data  input  DATA_W  source 0 beat data.
- s0_last  input  1  source 0 beat is the final beat of its packet.
- s0_ready  output  1  source 0 beat accepted this cycle when high together with s0_valid.
- s1_valid, s1_data, s1_last, s1_ready: same as source 0, for source 1.
- m_valid  output  1  output beat valid.
- m_data  output  DATA_W  output beat data.
- m_last  output  1  output beat ends its packet.
- m_sel  output  1  index of the source that produced the current output beat.
- m_ready  input  1  downstream accepts the output beat.

## Operation
- Reset values: m_valid=0, m_data=0, m_last=0, m_sel=0, state=IDLE, last_grant=1. With last_grant=1, source 0 wins the first tie.
- Load enable is load = !m_valid || m_ready. A beat is accepted from a source only when load=1.
- State machine has three states: IDLE, LOCK0, LOCK1.
- IDLE:
  - If exactly one source is valid, that source is granted.
  - If both sources are valid, source ~last_grant is granted.
  - The granted source's ready equals load; the other source's ready is 0.
  - On an accepted beat with last=1: stay in IDLE and set last_grant to the granted source.
  - On an accepted beat with last=0: go to LOCKx, where x is the granted source.
- LOCKx:
  - sx_ready equals load; the other source's ready is held at 0, even if it is valid.
  - On an accepted beat from x with last=1: go to IDLE and set last_grant=x.
  - Source x deasserting valid mid-packet is legal. The mux stays in LOCKx; there is no timeout.
- On every accepted beat, the output register loads data, last and sel, and sets m_valid=1.
- If load=1 and no beat is accepted, m_valid clears to 0.
- Ready outputs depend combinationally on m_ready and, in IDLE, on both valids. Sources must not make valid depend on ready.
- Packets are never interleaved on the output. Beat order within a packet is preserved.
- An asynchronous reset asserted mid-packet clears all state. Any beat held in the output register is discarded. After reset, a source must restart at a packet boundary.

## Timing
- Latency: a beat accepted at edge N is presented on m_* from edge N, and is visible during cycle N+1.
- Throughput: with m_ready held high, one beat per cycle, including back-to-back packets from alternating sources. There is no idle cycle between packets.
- Backpressure: when m_valid=1 and m_ready=0, both s*_ready outputs are 0 and the m_* outputs hold stable.
- Simultaneous events: while m_ready=1, the output beat leaves and the next beat loads in the same cycle.
- Arbitration decision: made in the same cycle as acceptance. There is no grant-only cycle.

## Structure
- Shared package stream_mux_pkg contains:
  - the state typedef (IDLE, LOCK0, LOCK1);
  - the default DATA_W constant.
- Sub-module rr_arb2 is a natural split: the combinational two-request round-robin grant with a last_grant input. It is reusable for wider muxes later.
- The top level holds the FSM, the last_grant register and the output register.

## Test plan
- Single source: s0 sends a 3-beat packet A0,A1,A2 (last on A2) with m_ready=1. Required: m_data shows A0,A1,A2 on consecutive cycles, m_sel=0 throughout, m_last=1 only on A2.
- Tie after reset: s0 and s1 both assert valid with single-beat packets 0x11 and 0x22. Required: 0x11 with m_sel=0, then 0x22 with m_sel=1, on back-to-back cycles.
- Lock: s0 sends a 2-beat packet while s1 is valid throughout. Required: s1_ready=0 until s0's last beat is accepted, and s1's beat appears immediately after, with no gap.
- Backpressure: m_ready=0 for 3 cycles mid-packet. Required: m_* stable, both readies 0, and no beat lost or duplicated once m_ready returns to 1.
- Fairness: both sources continuously send single-beat packets. Required: m_sel alternates 0,1,0,1 over 8 beats.
- Reset mid-packet: assert rst_n=0 after beat 1 of a 3-beat packet. Required: m_valid=0 immediately. After release, the state is IDLE and a tie goes to s0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and defaults for the two-source packet stream multiplexer.
// The arbiter and the top-level FSM both import this package.
package stream_mux_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // FSM state encoding; 2'd3 is unused and behaves like IDLE.
    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t LOCK0 = 2'd1;
    localparam state_t LOCK1 = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-request round-robin arbiter.
// On a tie the request that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    always_comb begin
        gnt_vld_o = |req_i;
        case (req_i)
            2'b01:   gnt_idx_o = 1'b0;
            2'b10:   gnt_idx_o = 1'b1;
            2'b11:   gnt_idx_o = ~last_grant_i;
            default: gnt_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/stream_mux_2to1.sv
// Two-to-one valid/ready packet multiplexer with round-robin arbitration at
// packet boundaries and a single output register (one beat per cycle).
module stream_mux_2to1
    import stream_mux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_last,
    output logic              s0_ready,

    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              s1_ready,

    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_sel,
    input  logic              m_ready
);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic              m_sel_q, m_sel_d;

    logic              arb_vld;
    logic              arb_idx;
    logic              load;
    logic              locked;
    logic              sel;
    logic              cand_vld;
    logic              grant_en;
    logic              accept;
    logic              beat_last;
    logic [DATA_W-1:0] beat_data;

    rr_arb2 u_arb (
        .req_i        ({s1_valid, s0_valid}),
        .last_grant_i (last_grant_q),
        .gnt_vld_o    (arb_vld),
        .gnt_idx_o    (arb_idx)
    );

    // The output register may take a new beat when empty or being drained.
    assign load = !m_valid_q || m_ready;

    always_comb begin
        locked   = 1'b0;
        sel      = arb_idx;
        cand_vld = arb_vld;
        case (state_q)
            LOCK0: begin
                locked   = 1'b1;
                sel      = 1'b0;
                cand_vld = s0_valid;
            end
            LOCK1: begin
                locked   = 1'b1;
                sel      = 1'b1;
                cand_vld = s1_valid;
            end
            default: begin
                locked   = 1'b0;
                sel      = arb_idx;
                cand_vld = arb_vld;
            end
        endcase
    end

    // While locked, the owner sees ready even if it has paused mid-packet.
    assign grant_en  = locked || arb_vld;
    assign s0_ready  = load && grant_en && !sel;
    assign s1_ready  = load && grant_en &&  sel;
    assign accept    = load && cand_vld;
    assign beat_last = sel ? s1_last : s0_last;
    assign beat_data = sel ? s1_data : s0_data;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            if (beat_last) begin
                state_d      = IDLE;
                last_grant_d = sel;
            end else begin
                state_d      = sel ? LOCK1 : LOCK0;
            end
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_sel_d   = m_sel_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = beat_data;
            m_last_d  = beat_last;
            m_sel_d   = sel;
        end else if (load) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_sel_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            m_sel_q      <= m_sel_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_sel   = m_sel_q;

endmodule

// File: tb/tb_stream_mux_2to1.sv
// Bench for stream_mux_2to1: directed vector table, hand-written corner
// sequences, then randomized traffic against a packet-level reference model.
module tb_stream_mux_2to1;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s0_valid, s0_last, s0_ready;
    logic [DW-1:0] s0_data;
    logic          s1_valid, s1_last, s1_ready;
    logic [DW-1:0] s1_data;
    logic          m_valid, m_last, m_sel, m_ready;
    logic [DW-1:0] m_data;

    int n_chk  = 0;
    int n_fail = 0;

    stream_mux_2to1 #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_last  (s0_last),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_last  (s1_last),
        .s1_ready (s1_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_sel    (m_sel),
        .m_ready  (m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          s0v;
        logic [DW-1:0] s0d;
        logic          s0l;
        logic          s1v;
        logic [DW-1:0] s1d;
        logic          s1l;
        logic          mr;
        logic          e_r0;
        logic          e_r1;
        logic          e_mv;
        logic [DW-1:0] e_md;
        logic          e_ml;
        logic          e_ms;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mkv(input logic s0v, input logic [DW-1:0] s0d, input logic s0l,
                                 input logic s1v, input logic [DW-1:0] s1d, input logic s1l,
                                 input logic mr, input logic r0, input logic r1,
                                 input logic mv, input logic [DW-1:0] md, input logic ml,
                                 input logic ms);
        vec_t v;
        v.s0v = s0v; v.s0d = s0d; v.s0l = s0l;
        v.s1v = s1v; v.s1d = s1d; v.s1l = s1l;
        v.mr = mr; v.e_r0 = r0; v.e_r1 = r1;
        v.e_mv = mv; v.e_md = md; v.e_ml = ml; v.e_ms = ms;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s0v, input logic [DW-1:0] s0d, input logic s0l,
                         input logic s1v, input logic [DW-1:0] s1d, input logic s1l,
                         input logic mr);
        s0_valid = s0v; s0_data = s0d; s0_last = s0l;
        s1_valid = s1v; s1_data = s1d; s1_last = s1l;
        m_ready  = mr;
    endtask

    // Ends one time unit after a rising edge with reset released.
    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Random-phase source and model state.
    logic          pres[2];
    logic [DW-1:0] dat[2];
    logic          lst[2];
    int            plen[2];
    int            bidx[2];
    logic [6:0]    cnt[2];
    int            owner;
    int            lg;
    logic          mv_m, ml_m, ms_m;
    logic [DW-1:0] md_m;

    initial begin
        logic [DW-1:0] d0, d1;
        int            k0, k1;
        logic          load_m, acc, er0, er1;
        int            g;

        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("reset m_valid", 32'(m_valid), 32'(0));
        chk("reset m_data",  32'(m_data),  32'(0));
        chk("reset m_last",  32'(m_last),  32'(0));
        chk("reset m_sel",   32'(m_sel),   32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //            s0v s0d    s0l  s1v s1d    s1l  mr   r0   r1   mv   md     ml   ms
        tbl[0]  = mkv(1, 8'h11, 1,   1, 8'h22, 1,   1,   1,   0,   1, 8'h11, 1,   0);
        tbl[1]  = mkv(0, 8'h00, 0,   1, 8'h22, 1,   1,   0,   1,   1, 8'h22, 1,   1);
        tbl[2]  = mkv(1, 8'hA0, 0,   0, 8'h00, 0,   1,   1,   0,   1, 8'hA0, 0,   0);
        tbl[3]  = mkv(1, 8'hA1, 0,   0, 8'h00, 0,   1,   1,   0,   1, 8'hA1, 0,   0);
        tbl[4]  = mkv(1, 8'hA2, 1,   0, 8'h00, 0,   1,   1,   0,   1, 8'hA2, 1,   0);
        tbl[5]  = mkv(0, 8'h00, 0,   1, 8'h33, 1,   1,   0,   1,   1, 8'h33, 1,   1);
        tbl[6]  = mkv(1, 8'hB0, 0,   1, 8'hC0, 1,   1,   1,   0,   1, 8'hB0, 0,   0);
        tbl[7]  = mkv(1, 8'hB1, 1,   1, 8'hC0, 1,   1,   1,   0,   1, 8'hB1, 1,   0);
        tbl[8]  = mkv(0, 8'h00, 0,   1, 8'hC0, 1,   1,   0,   1,   1, 8'hC0, 1,   1);
        tbl[9]  = mkv(1, 8'hE0, 0,   0, 8'h00, 0,   1,   1,   0,   1, 8'hE0, 0,   0);
        tbl[10] = mkv(1, 8'hE1, 0,   1, 8'h44, 1,   0,   0,   0,   1, 8'hE0, 0,   0);
        tbl[11] = mkv(1, 8'hE1, 0,   1, 8'h44, 1,   0,   0,   0,   1, 8'hE0, 0,   0);
        tbl[12] = mkv(1, 8'hE1, 0,   1, 8'h44, 1,   0,   0,   0,   1, 8'hE0, 0,   0);
        tbl[13] = mkv(1, 8'hE1, 0,   1, 8'h44, 1,   1,   1,   0,   1, 8'hE1, 0,   0);
        tbl[14] = mkv(0, 8'h00, 0,   1, 8'h44, 1,   1,   1,   0,   0, 8'h00, 0,   0);
        tbl[15] = mkv(1, 8'hE2, 1,   1, 8'h44, 1,   1,   1,   0,   1, 8'hE2, 1,   0);
        tbl[16] = mkv(0, 8'h00, 0,   1, 8'h44, 1,   1,   0,   1,   1, 8'h44, 1,   1);
        tbl[17] = mkv(0, 8'h00, 0,   0, 8'h00, 0,   1,   0,   0,   0, 8'h00, 0,   0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].s0v, tbl[i].s0d, tbl[i].s0l, tbl[i].s1v, tbl[i].s1d, tbl[i].s1l, tbl[i].mr);
            #1;
            chk($sformatf("row%0d s0_ready", i), 32'(s0_ready), 32'(tbl[i].e_r0));
            chk($sformatf("row%0d s1_ready", i), 32'(s1_ready), 32'(tbl[i].e_r1));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
            if (tbl[i].e_mv) begin
                chk($sformatf("row%0d m_data", i), 32'(m_data), 32'(tbl[i].e_md));
                chk($sformatf("row%0d m_last", i), 32'(m_last), 32'(tbl[i].e_ml));
                chk($sformatf("row%0d m_sel", i),  32'(m_sel),  32'(tbl[i].e_ms));
            end
        end

        // Fairness: both sources stream single-beat packets continuously.
        do_reset();
        k0 = 0;
        k1 = 0;
        for (int i = 0; i < 8; i++) begin
            d0 = 8'(8'h80 + k0);
            d1 = 8'(8'h90 + k1);
            drive(1'b1, d0, 1'b1, 1'b1, d1, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("fair%0d m_valid", i), 32'(m_valid), 32'(1));
            chk($sformatf("fair%0d m_sel", i), 32'(m_sel), 32'(i % 2));
            chk($sformatf("fair%0d m_data", i), 32'(m_data), 32'((i % 2 == 0) ? d0 : d1));
            if (i % 2 == 0) k0++;
            else k1++;
        end

        // Reset asserted while a 3-beat packet is in flight.
        do_reset();
        drive(1'b1, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("midrst beat1 m_data", 32'(m_data), 32'(8'hF0));
        drive(1'b1, 8'hF1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst m_valid", 32'(m_valid), 32'(0));
        chk("midrst m_data",  32'(m_data),  32'(0));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
        #1;
        chk("postrst idle s1_ready", 32'(s1_ready), 32'(1));
        drive(1'b1, 8'h55, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1);
        #1;
        chk("postrst tie s0_ready", 32'(s0_ready), 32'(1));
        chk("postrst tie s1_ready", 32'(s1_ready), 32'(0));
        @(posedge clk);
        #1;
        chk("postrst m_data", 32'(m_data), 32'(8'h55));
        chk("postrst m_sel",  32'(m_sel),  32'(0));

        // Randomized traffic against the packet-level model.
        do_reset();
        owner = -1;
        lg    = 1;
        mv_m  = 1'b0;
        md_m  = '0;
        ml_m  = 1'b0;
        ms_m  = 1'b0;
        for (int s = 0; s < 2; s++) begin
            pres[s] = 1'b0;
            dat[s]  = '0;
            lst[s]  = 1'b0;
            plen[s] = 1;
            bidx[s] = 0;
            cnt[s]  = '0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (!pres[s] && $urandom_range(9) < 7) begin
                    if (bidx[s] == 0) plen[s] = $urandom_range(4, 1);
                    pres[s] = 1'b1;
                    dat[s]  = {s[0], cnt[s]};
                    cnt[s]  = cnt[s] + 7'd1;
                    lst[s]  = (bidx[s] == plen[s] - 1);
                end
            end
            drive(pres[0], dat[0], lst[0], pres[1], dat[1], lst[1], ($urandom_range(3) != 0));
            #1;
            load_m = !mv_m || m_ready;
            if (owner >= 0)              g = owner;
            else if (pres[0] && pres[1]) g = 1 - lg;
            else if (pres[0])            g = 0;
            else if (pres[1])            g = 1;
            else                         g = -1;
            er0 = load_m && (g == 0);
            er1 = load_m && (g == 1);
            acc = load_m && (g >= 0) && pres[(g < 0) ? 0 : g];
            chk($sformatf("rnd%0d s0_ready", c), 32'(s0_ready), 32'(er0));
            chk($sformatf("rnd%0d s1_ready", c), 32'(s1_ready), 32'(er1));
            @(posedge clk);
            #1;
            if (acc) begin
                mv_m = 1'b1;
                md_m = dat[g];
                ml_m = lst[g];
                ms_m = g[0];
                pres[g] = 1'b0;
                if (lst[g]) begin
                    owner   = -1;
                    lg      = g;
                    bidx[g] = 0;
                end else begin
                    owner   = g;
                    bidx[g] = bidx[g] + 1;
                end
            end else if (load_m) begin
                mv_m = 1'b0;
            end
            chk($sformatf("rnd%0d m_valid", c), 32'(m_valid), 32'(mv_m));
            if (mv_m) begin
                chk($sformatf("rnd%0d m_data", c), 32'(m_data), 32'(md_m));
                chk($sformatf("rnd%0d m_last", c), 32'(m_last), 32'(ml_m));
                chk($sformatf("rnd%0d m_sel", c),  32'(m_sel),  32'(ms_m));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
